// File: rtl/cascade_stage_sequencer.sv
// rtl/cascade_stage_sequencer.sv - 22-stage Haar cascade sequencer for one detection window at a time
// Optional per-window statistics counters are enabled by defining CASCADE_STATS_EN.
`timescale 1ns/1ps
module cascade_stage_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int SCORE_W    = 24,
  parameter int FRAC_W     = 12,
  parameter int ACC_W      = 32,
  parameter int IDX_W      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic               abort,
  output logic               feat_req_valid,
  input  logic               feat_req_ready,
  output logic [IDX_W-1:0]   feat_req_idx,
  input  logic               feat_rsp_valid,
  input  logic [SCORE_W-1:0] feat_rsp_score,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               result_face,
  output logic [4:0]         result_stage
`ifdef CASCADE_STATS_EN
  ,
  output logic [31:0]                stat_windows,
  output logic [31:0]                stat_faces,
  output logic [NUM_STAGES*16-1:0]   stat_reject_hist
`endif
);

  // Threshold ROM values are stored in Q.12 and shifted up for wider fractions.
  localparam int THR_SHIFT = FRAC_W - 12;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_RESULT} state_t;

  state_t                   state, state_next;
  logic [4:0]               stage;
  logic [IDX_W-1:0]         idx;
  logic [7:0]               cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               stage_cnt;
  logic signed [ACC_W-1:0]  stage_thr;
  logic signed [ACC_W-1:0]  score_ext;
  logic                     pass, last_stage, stage_done;

  function automatic logic [7:0] count_rom(input logic [4:0] s);
    case (s)
      5'd0:  count_rom = 8'd3;    5'd1:  count_rom = 8'd16;
      5'd2:  count_rom = 8'd21;   5'd3:  count_rom = 8'd39;
      5'd4:  count_rom = 8'd33;   5'd5:  count_rom = 8'd44;
      5'd6:  count_rom = 8'd50;   5'd7:  count_rom = 8'd51;
      5'd8:  count_rom = 8'd56;   5'd9:  count_rom = 8'd71;
      5'd10: count_rom = 8'd80;   5'd11: count_rom = 8'd103;
      5'd12: count_rom = 8'd111;  5'd13: count_rom = 8'd102;
      5'd14: count_rom = 8'd135;  5'd15: count_rom = 8'd137;
      5'd16: count_rom = 8'd140;  5'd17: count_rom = 8'd160;
      5'd18: count_rom = 8'd177;  5'd19: count_rom = 8'd182;
      5'd20: count_rom = 8'd211;  5'd21: count_rom = 8'd213;
      default: count_rom = 8'd0;
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] thr_rom(input logic [4:0] s);
    logic signed [31:0] raw;
    case (s)
      5'd0:  raw = 32'sd3370;    5'd1:  raw = 32'sd28494;
      5'd2:  raw = 32'sd38906;   5'd3:  raw = 32'sd75420;
      5'd4:  raw = 32'sd62768;   5'd5:  raw = 32'sd86060;
      5'd6:  raw = 32'sd97971;   5'd7:  raw = 32'sd100466;
      5'd8:  raw = 32'sd111220;  5'd9:  raw = 32'sd141534;
      5'd10: raw = 32'sd160183;  5'd11: raw = 32'sd207301;
      5'd12: raw = 32'sd223724;  5'd13: raw = 32'sd205495;
      5'd14: raw = 32'sd273077;  5'd15: raw = 32'sd277295;
      5'd16: raw = 32'sd283566;  5'd17: raw = 32'sd324604;
      5'd18: raw = 32'sd359203;  5'd19: raw = 32'sd369678;
      5'd20: raw = 32'sd429053;  5'd21: raw = 32'sd433197;
      default: raw = 32'sd0;
    endcase
    thr_rom = ACC_W'(raw) <<< THR_SHIFT;
  endfunction

  assign feat_req_idx = idx;

  always_comb begin
    stage_cnt  = count_rom(stage);
    stage_thr  = thr_rom(stage);
    score_ext  = {{(ACC_W-SCORE_W){feat_rsp_score[SCORE_W-1]}}, feat_rsp_score};
    pass       = acc >= stage_thr;
    last_stage = stage == 5'(NUM_STAGES-1);
    stage_done = (cnt + 8'd1) == stage_cnt;
    state_next = state;
    case (state)
      S_IDLE:   if (win_valid && win_ready) state_next = S_ISSUE;
      S_ISSUE:  if (feat_req_ready) state_next = S_WAIT;
      S_WAIT:   if (feat_rsp_valid) state_next = stage_done ? S_CHECK : S_ISSUE;
      S_CHECK:  state_next = (pass && !last_stage) ? S_ISSUE : S_RESULT;
      S_RESULT: if (result_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    // abort is meaningless in IDLE, so a simultaneous win_valid still wins there
    if (abort && state != S_IDLE) state_next = S_IDLE;
  end

  // Handshake outputs are registered from the next state so they read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      win_ready      <= 1'b0;
      feat_req_valid <= 1'b0;
      result_valid   <= 1'b0;
      result_face    <= 1'b0;
      result_stage   <= 5'd0;
      stage          <= 5'd0;
      idx            <= '0;
      cnt            <= 8'd0;
      acc            <= '0;
    end else begin
      state          <= state_next;
      win_ready      <= state_next == S_IDLE;
      feat_req_valid <= state_next == S_ISSUE;
      result_valid   <= state_next == S_RESULT;
      case (state)
        S_IDLE: if (win_valid && win_ready) begin
          stage <= 5'd0;
          idx   <= '0;
          cnt   <= 8'd0;
          acc   <= '0;
        end
        S_WAIT: if (feat_rsp_valid && !abort) begin
          acc <= acc + score_ext;
          idx <= idx + IDX_W'(1);
          cnt <= cnt + 8'd1;
        end
        S_CHECK: if (!abort) begin
          if (pass && !last_stage) begin
            stage <= stage + 5'd1;
            acc   <= '0;
            cnt   <= 8'd0;
          end else begin
            result_face  <= pass;
            result_stage <= pass ? 5'(NUM_STAGES) : stage;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CASCADE_STATS_EN
  logic stat_hs;
  assign stat_hs = result_valid && result_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_windows     <= 32'd0;
      stat_faces       <= 32'd0;
      stat_reject_hist <= '0;
    end else if (stat_hs) begin
      if (stat_windows != 32'hFFFF_FFFF) stat_windows <= stat_windows + 32'd1;
      if (result_face && stat_faces != 32'hFFFF_FFFF) stat_faces <= stat_faces + 32'd1;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (!result_face && result_stage == 5'(i) && stat_reject_hist[i*16 +: 16] != 16'hFFFF)
          stat_reject_hist[i*16 +: 16] <= stat_reject_hist[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
